// File: rtl/spi_master_xfer_arb.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_xfer_arb
// Description : Round-robin arbiter sharing one SPI master core between two
//               transfer requesters, with a watchdog abort that soft-resets
//               the core. Optional macro SPI_ARB_LOCK_EN adds req_lock
//               (sticky re-grant of the last requester).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_xfer_arb #(
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 16'hFFFF,
    parameter int IDLE_BIT  = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr,
    input  logic [63:0] req_cmd,
    input  logic [11:0] req_cmd_len,
    input  logic [63:0] req_addr,
    input  logic [11:0] req_addr_len,
    input  logic [31:0] req_data_len,
    input  logic [7:0]  req_cs,
`ifdef SPI_ARB_LOCK_EN
    input  logic [1:0]  req_lock,
`endif
    input  logic [63:0] req_tx_data,
    input  logic [1:0]  req_tx_valid,
    output logic [1:0]  req_tx_ready,
    output logic [31:0] req_rx_data,
    output logic [1:0]  req_rx_valid,
    input  logic [1:0]  req_rx_ready,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    input  logic [31:0] spi_status,
    output logic [31:0] spi_cmd,
    output logic [5:0]  spi_cmd_len,
    output logic [31:0] spi_addr,
    output logic [5:0]  spi_addr_len,
    output logic [15:0] spi_data_len,
    output logic [3:0]  spi_csreg,
    output logic        spi_rd,
    output logic        spi_wr,
    output logic        spi_swrst,
    output logic [31:0] spi_data_tx,
    output logic        spi_data_tx_valid,
    input  logic        spi_data_tx_ready,
    input  logic [31:0] spi_data_rx,
    input  logic        spi_data_rx_valid,
    output logic        spi_data_rx_ready
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4,
        S_ABORT     = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [TIMEOUT_W-1:0] c_WDOG_LIMIT = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] c_WDOG_ONE   = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] c_WDOG_MAX   = '1;

    state_t                 r_state;
    logic                   r_last_grant;
    logic                   r_g;
    logic                   r_wr;
    logic [31:0]            r_cmd;
    logic [31:0]            r_addr;
    logic [5:0]             r_cmd_len;
    logic [5:0]             r_addr_len;
    logic [15:0]            r_data_len;
    logic [3:0]             r_cs;
    logic [1:0]             r_wait_cnt;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic [1:0]             r_done;
    logic [1:0]             r_err;
`ifdef SPI_ARB_LOCK_EN
    logic                   r_lock;
`endif

    logic w_grant;
    logic w_take;
    logic w_run;
    logic w_hs;
    logic w_core_idle;
    logic w_unused_status;

    // Prefer the requester that did not win last time; fall back to whoever is valid.
    always_comb begin
        w_grant = ~r_last_grant;
        if (!req_valid[~r_last_grant])
            w_grant = r_last_grant;
`ifdef SPI_ARB_LOCK_EN
        if (r_lock && req_valid[r_g])
            w_grant = r_g;
`endif
    end

    assign w_take      = (r_state == S_IDLE) && (|req_valid) && !HRESET;
    assign req_ready   = w_take ? (2'b01 << w_grant) : 2'b00;
    assign w_run       = (r_state == S_RUN);
    assign w_core_idle = spi_status[IDLE_BIT];
    assign w_unused_status = ^spi_status;

    // Data paths are only live while the granted transfer is running.
    assign spi_data_tx       = w_run ? (r_g ? req_tx_data[63:32] : req_tx_data[31:0]) : 32'd0;
    assign spi_data_tx_valid = w_run && req_tx_valid[r_g];
    assign req_tx_ready      = (w_run && spi_data_tx_ready) ? (2'b01 << r_g) : 2'b00;
    assign req_rx_data       = w_run ? spi_data_rx : 32'd0;
    assign req_rx_valid      = (w_run && spi_data_rx_valid) ? (2'b01 << r_g) : 2'b00;
    assign spi_data_rx_ready = w_run && req_rx_ready[r_g];
    assign w_hs = (spi_data_tx_valid && spi_data_tx_ready) ||
                  (spi_data_rx_valid && spi_data_rx_ready);

    assign req_done = r_done;
    assign req_err  = r_err;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_g          <= 1'b0;
            r_wr         <= 1'b0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_cmd_len    <= '0;
            r_addr_len   <= '0;
            r_data_len   <= '0;
            r_cs         <= '0;
            r_wait_cnt   <= '0;
            r_wdog       <= '0;
            r_done       <= '0;
            r_err        <= '0;
            spi_cmd      <= '0;
            spi_cmd_len  <= '0;
            spi_addr     <= '0;
            spi_addr_len <= '0;
            spi_data_len <= '0;
            spi_csreg    <= '0;
            spi_rd       <= 1'b0;
            spi_wr       <= 1'b0;
            spi_swrst    <= 1'b0;
`ifdef SPI_ARB_LOCK_EN
            r_lock       <= 1'b0;
`endif
        end else begin
            spi_rd    <= 1'b0;
            spi_wr    <= 1'b0;
            spi_swrst <= 1'b0;
            r_done    <= 2'b00;
            r_err     <= 2'b00;
            case (r_state)
                S_IDLE: begin
`ifdef SPI_ARB_LOCK_EN
                    r_lock <= 1'b0;
`endif
                    if (w_take) begin
                        r_g        <= w_grant;
                        r_wr       <= req_wr[w_grant];
                        r_cmd      <= w_grant ? req_cmd[63:32]      : req_cmd[31:0];
                        r_cmd_len  <= w_grant ? req_cmd_len[11:6]   : req_cmd_len[5:0];
                        r_addr     <= w_grant ? req_addr[63:32]     : req_addr[31:0];
                        r_addr_len <= w_grant ? req_addr_len[11:6]  : req_addr_len[5:0];
                        r_data_len <= w_grant ? req_data_len[31:16] : req_data_len[15:0];
                        r_cs       <= w_grant ? req_cs[7:4]         : req_cs[3:0];
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    spi_cmd      <= r_cmd;
                    spi_cmd_len  <= r_cmd_len;
                    spi_addr     <= r_addr;
                    spi_addr_len <= r_addr_len;
                    spi_data_len <= r_data_len;
                    spi_csreg    <= r_cs;
                    r_last_grant <= r_g;
                    // Start pulse is registered so it lines up with the START state.
                    spi_wr       <= r_wr;
                    spi_rd       <= !r_wr;
                    r_state      <= S_START;
                end
                S_START: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    r_wdog <= '0;
                    if (!w_core_idle) begin
                        r_state <= S_RUN;
                    end else if (r_wait_cnt == 2'd3) begin
                        r_done  <= 2'b01 << r_g;
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                S_RUN: begin
                    if (w_hs)
                        r_wdog <= '0;
                    else if (r_wdog != c_WDOG_MAX)
                        r_wdog <= r_wdog + c_WDOG_ONE;
                    if (w_core_idle) begin
                        r_done  <= 2'b01 << r_g;
                        r_state <= S_DONE;
                    end else if (r_wdog == c_WDOG_LIMIT) begin
                        spi_swrst <= 1'b1;
                        r_state   <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    r_done  <= 2'b01 << r_g;
                    r_err   <= 2'b01 << r_g;
                    r_state <= S_DONE;
                end
                S_DONE: begin
`ifdef SPI_ARB_LOCK_EN
                    r_lock <= req_lock[r_g];
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_xfer_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_xfer_arb
// Description : Scoreboard bench for spi_master_xfer_arb with a small SPI core
//               responder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_xfer_arb;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [1:0]  req_valid = '0, req_ready, req_wr = '0;
    logic [63:0] req_cmd = '0, req_addr = '0, req_tx_data = '0;
    logic [11:0] req_cmd_len = '0, req_addr_len = '0;
    logic [31:0] req_data_len = '0;
    logic [7:0]  req_cs = '0;
    logic [1:0]  req_tx_valid = '0, req_tx_ready, req_rx_valid, req_rx_ready = '0;
    logic [31:0] req_rx_data;
    logic [1:0]  req_done, req_err;
    logic [31:0] spi_status, spi_cmd, spi_addr, spi_data_tx, spi_data_rx;
    logic [5:0]  spi_cmd_len, spi_addr_len;
    logic [15:0] spi_data_len;
    logic [3:0]  spi_csreg;
    logic        spi_rd, spi_wr, spi_swrst;
    logic        spi_data_tx_valid, spi_data_tx_ready, spi_data_rx_valid, spi_data_rx_ready;
`ifdef SPI_ARB_LOCK_EN
    logic [1:0]  req_lock = '0;
`endif

    always #5 HCLK = ~HCLK;

    spi_master_xfer_arb #(.TIMEOUT_W(16), .TIMEOUT(16), .IDLE_BIT(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_cmd(req_cmd), .req_cmd_len(req_cmd_len),
        .req_addr(req_addr), .req_addr_len(req_addr_len),
        .req_data_len(req_data_len), .req_cs(req_cs),
`ifdef SPI_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_tx_data(req_tx_data), .req_tx_valid(req_tx_valid), .req_tx_ready(req_tx_ready),
        .req_rx_data(req_rx_data), .req_rx_valid(req_rx_valid), .req_rx_ready(req_rx_ready),
        .req_done(req_done), .req_err(req_err), .spi_status(spi_status),
        .spi_cmd(spi_cmd), .spi_cmd_len(spi_cmd_len), .spi_addr(spi_addr),
        .spi_addr_len(spi_addr_len), .spi_data_len(spi_data_len), .spi_csreg(spi_csreg),
        .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_swrst(spi_swrst),
        .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid),
        .spi_data_tx_ready(spi_data_tx_ready), .spi_data_rx(spi_data_rx),
        .spi_data_rx_valid(spi_data_rx_valid), .spi_data_rx_ready(spi_data_rx_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    // ---------------- SPI core responder model ----------------
    logic        core_busy = 1'b0, core_is_wr = 1'b0, start_dly = 1'b0;
    int          core_cnt = 0;
    int          core_words = 1;
    bit          never_busy = 0, tx_stall = 0, rx_hold = 0;
    logic [31:0] rx_word = 32'h0;

    always @(posedge HCLK) begin
        if (HRESET) begin
            core_busy <= 1'b0;
            start_dly <= 1'b0;
        end else if (spi_swrst) begin
            core_busy <= 1'b0;
            start_dly <= 1'b0;
        end else if (spi_rd || spi_wr) begin
            core_is_wr <= spi_wr;
            core_cnt   <= 0;
            start_dly  <= !never_busy;
        end else if (start_dly) begin
            start_dly <= 1'b0;
            core_busy <= 1'b1;
        end else if (core_busy) begin
            if (core_is_wr ? (spi_data_tx_valid && spi_data_tx_ready)
                           : (spi_data_rx_valid && spi_data_rx_ready)) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt + 1 == core_words) core_busy <= 1'b0;
            end
        end
    end

    assign spi_status        = {31'd0, ~core_busy};
    assign spi_data_tx_ready = core_busy && core_is_wr && !tx_stall;
    assign spi_data_rx_valid = core_busy && !core_is_wr && !rx_hold;
    assign spi_data_rx       = rx_word + 32'(core_cnt);

    // ---------------- scoreboard / monitor ----------------
    int          exp_grant[$];
    int          exp_done[$];       // requester + 2*err
    logic [31:0] exp_rx[$];
    logic [31:0] exp_tx[$];

    int cyc = 0;
    int g_cnt = 0, rd_cnt = 0, wr_cnt = 0, swrst_cnt = 0, done_cnt = 0, viol = 0;
    int cur_g = 0, ready_cyc = 0, start_cyc = 0, done_cyc = 0, swrst_cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (req_ready != 2'b00) begin
                g_cnt++;
                ready_cyc = cyc;
                cur_g = int'(req_ready[1]);
                if (exp_grant.size() != 0) check_val("grant", 64'(req_ready), 64'(onehot(exp_grant.pop_front())));
                else check_val("grant_unexpected", 64'(req_ready), 64'd0);
            end
            if (spi_rd) begin rd_cnt++; start_cyc = cyc; end
            if (spi_wr) begin wr_cnt++; start_cyc = cyc; end
            if (spi_swrst) begin swrst_cnt++; swrst_cyc = cyc; end
            if (((req_tx_ready | req_rx_valid) & ~onehot(cur_g)) != 2'b00) viol++;
            if (spi_data_tx_valid && spi_data_tx_ready) begin
                if (exp_tx.size() != 0) check_val("tx_data", 64'(spi_data_tx), 64'(exp_tx.pop_front()));
                else check_val("tx_unexpected", 64'(spi_data_tx_valid), 64'd0);
            end
            if ((req_rx_valid & req_rx_ready) != 2'b00) begin
                check_val("rx_owner", 64'(req_rx_valid), 64'(onehot(cur_g)));
                if (exp_rx.size() != 0) check_val("rx_data", 64'(req_rx_data), 64'(exp_rx.pop_front()));
                else check_val("rx_unexpected", 64'(req_rx_valid), 64'd0);
            end
            if (req_done != 2'b00) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done.size() != 0) begin
                    int e;
                    e = exp_done.pop_front();
                    check_val("done_id", 64'(req_done), 64'(onehot(e % 2)));
                    check_val("done_err", 64'(req_err), (e >= 2) ? 64'(onehot(e % 2)) : 64'd0);
                end else begin
                    check_val("done_unexpected", 64'(req_done), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        step();
        HRESET = 1'b1;
        step();
        step();
        HRESET = 1'b0;
    endtask

    task automatic set_desc(input int i, input logic wr, input logic [31:0] cmd, input logic [5:0] clen,
                            input logic [31:0] addr, input logic [5:0] alen, input logic [15:0] dlen,
                            input logic [3:0] cs);
        req_wr[i]              = wr;
        req_cmd[i*32 +: 32]    = cmd;
        req_cmd_len[i*6 +: 6]  = clen;
        req_addr[i*32 +: 32]   = addr;
        req_addr_len[i*6 +: 6] = alen;
        req_data_len[i*16 +: 16] = dlen;
        req_cs[i*4 +: 4]       = cs;
    endtask

    task automatic wait_grants(input int target, input int budget);
        int k = 0;
        while (g_cnt < target && k < budget) begin step(); k++; end
        check_val("grant_count", 64'(g_cnt), 64'(target));
    endtask

    task automatic wait_dones(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin step(); k++; end
        check_val("done_count", 64'(done_cnt), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rd0, wr0, sw0, g0, v0;
        req_tx_valid = 2'b11;
        req_rx_ready = 2'b11;
        req_tx_data  = {32'hB1B1_0001, 32'hA0A0_0000};
        do_reset();

        // Reset state
        check_val("rst_ready", 64'(req_ready), 64'd0);
        check_val("rst_rd_wr", 64'({spi_rd, spi_wr, spi_swrst}), 64'd0);
        check_val("rst_done", 64'(req_done), 64'd0);
        check_val("rst_cmd", 64'(spi_cmd), 64'd0);
        check_val("rst_csreg", 64'(spi_csreg), 64'd0);
        check_val("rst_paths", 64'({spi_data_tx_valid, spi_data_rx_ready, req_tx_ready, req_rx_valid}), 64'd0);

        // Single read from requester 0
        set_desc(0, 1'b0, 32'h0B, 6'd8, 32'h1000, 6'd24, 16'd32, 4'h1);
        core_words = 1;
        rx_word    = 32'hDEADBEEF;
        exp_grant.push_back(0);
        exp_rx.push_back(32'hDEADBEEF);
        exp_done.push_back(0);
        rd0 = rd_cnt; wr0 = wr_cnt;
        req_valid = 2'b01;
        wait_grants(1, 50);
        req_valid = 2'b00;
        req_cmd[31:0] = 32'hFFFF_FFFF;
        wait_dones(1, 50);
        check_val("rd_latency", 64'(start_cyc - ready_cyc), 64'd2);
        check_val("rd_pulses", 64'(rd_cnt - rd0), 64'd1);
        check_val("rd_no_wr", 64'(wr_cnt - wr0), 64'd0);
        check_val("ld_cmd", 64'(spi_cmd), 64'h0B);
        check_val("ld_lens", 64'({spi_cmd_len, spi_addr_len, spi_data_len}), 64'({6'd8, 6'd24, 16'd32}));
        check_val("ld_addr_cs", 64'({spi_addr, spi_csreg}), 64'({32'h1000, 4'h1}));

        // Both requesters, three back-to-back writes each
        do_reset();
        set_desc(0, 1'b1, 32'h02, 6'd8, 32'h2000, 6'd24, 16'd64, 4'h1);
        set_desc(1, 1'b1, 32'h12, 6'd8, 32'h3000, 6'd24, 16'd64, 4'h2);
        core_words = 2;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 2; r++) begin
                exp_grant.push_back(r);
                exp_done.push_back(r);
                exp_tx.push_back(r == 0 ? 32'hA0A0_0000 : 32'hB1B1_0001);
                exp_tx.push_back(r == 0 ? 32'hA0A0_0000 : 32'hB1B1_0001);
            end
        end
        wr0 = wr_cnt; g0 = g_cnt; v0 = viol;
        req_valid = 2'b11;
        wait_grants(g0 + 6, 400);
        req_valid = 2'b00;
        wait_dones(7, 400);
        check_val("wr_pulses", 64'(wr_cnt - wr0), 64'd6);
        check_val("cross_talk", 64'(viol - v0), 64'd0);

        // TX backpressure -> watchdog abort
        do_reset();
        tx_stall   = 1;
        core_words = 1;
        set_desc(0, 1'b1, 32'h02, 6'd8, 32'h4000, 6'd24, 16'd32, 4'h1);
        exp_grant.push_back(0);
        exp_done.push_back(0 + 2);
        sw0 = swrst_cnt;
        req_valid = 2'b01;
        wait_grants(g_cnt + 1, 50);
        req_valid = 2'b00;
        wait_dones(8, 100);
        check_val("abort_pulses", 64'(swrst_cnt - sw0), 64'd1);
        check_val("abort_timing", 64'(swrst_cyc - start_cyc), 64'd19);
        repeat (70) step();
        check_val("abort_once", 64'(swrst_cnt - sw0), 64'd1);
        tx_stall = 0;

        // Core never goes busy -> zero-length completion
        do_reset();
        never_busy = 1;
        set_desc(1, 1'b0, 32'h03, 6'd8, 32'h5000, 6'd24, 16'd0, 4'h4);
        exp_grant.push_back(1);
        exp_done.push_back(1);
        req_valid = 2'b10;
        wait_grants(g_cnt + 1, 50);
        req_valid = 2'b00;
        wait_dones(9, 50);
        check_val("nobusy_timing", 64'(done_cyc - start_cyc), 64'd5);
        never_busy = 0;

        // Reset during RUN
        do_reset();
        rx_hold    = 1;
        core_words = 4;
        set_desc(1, 1'b0, 32'h0B, 6'd8, 32'h6000, 6'd24, 16'd128, 4'h8);
        exp_grant.push_back(1);
        sw0 = swrst_cnt; rd0 = rd_cnt;
        req_valid = 2'b10;
        wait_grants(g_cnt + 1, 50);
        req_valid = 2'b00;
        begin
            int k = 0;
            while (rd_cnt == rd0 && k < 20) begin step(); k++; end
        end
        repeat (3) step();
        check_val("in_run", 64'(spi_data_rx_ready), 64'd1);
        HRESET = 1'b1;
        step();
        check_val("mid_rst_regs", 64'({spi_cmd, spi_csreg, spi_rd, spi_wr, spi_swrst}), 64'd0);
        check_val("mid_rst_paths", 64'({req_done, req_rx_valid, spi_data_rx_ready, spi_data_tx_valid}), 64'd0);
        HRESET  = 1'b0;
        rx_hold = 0;
        core_words = 1;
        rx_word = 32'h1234_5678;
        set_desc(0, 1'b0, 32'h0B, 6'd8, 32'h7000, 6'd24, 16'd32, 4'h1);
        exp_grant.push_back(0);
        exp_rx.push_back(32'h1234_5678);
        exp_done.push_back(0);
        req_valid = 2'b11;
        wait_grants(g_cnt + 1, 50);
        req_valid = 2'b00;
        wait_dones(10, 50);
        check_val("mid_rst_no_swrst", 64'(swrst_cnt - sw0), 64'd0);

        repeat (5) step();
        check_val("queues_empty", 64'(exp_grant.size() + exp_done.size() + exp_rx.size() + exp_tx.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_xfer_arb.md
Name: spi_master_xfer_arb

Overview:
- Shares one SPI master core between two requesters. Each requester is a transaction descriptor plus TX/RX data streams.
- Round-robin arbitration between the two requesters.
- For the granted requester, the block loads cmd/addr/len/cs into the core, issues a one-cycle start pulse, routes data both ways, waits for the core to go idle, and reports completion.
- A watchdog counter turns a stalled transfer into a soft reset of the core and an error completion.
- Sits between the on-chip masters (DMA, boot loader) and the SPI master core, on the same control/data signals the APB register interface drives.

Parameters:
- TIMEOUT_W, 16: width of the watchdog counter.
- TIMEOUT, 16'hFFFF: RUN cycles without core idle before abort. Must fit in TIMEOUT_W bits.
- IDLE_BIT, 0: index of the "core idle" bit in spi_status.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- req_valid  in  2  descriptor valid, one bit per requester i
- req_ready  out  2  descriptor accepted for requester i
- req_wr  in  2  1 = write transfer, 0 = read transfer
- req_cmd  in  64  command, requester i in [32i+31:32i]
- req_cmd_len  in  12  command length, [6i+5:6i]
- req_addr  in  64  address, [32i+31:32i]
- req_addr_len  in  12  address length, [6i+5:6i]
- req_data_len  in  32  data length, [16i+15:16i]
- req_cs  in  8  chip select, [4i+3:4i]
- req_tx_data  in  64  TX data, [32i+31:32i]
- req_tx_valid  in  2  TX data valid
- req_tx_ready  out  2  TX data ready
- req_rx_data  out  32  RX data, shared by both requesters
- req_rx_valid  out  2  RX data valid
- req_rx_ready  in  2  RX data ready
- req_done  out  2  one-cycle completion pulse
- req_err  out  2  valid with req_done; 1 = timeout abort
- spi_status  in  32  core status
- spi_cmd  out  32  to core
- spi_cmd_len  out  6  to core
- spi_addr  out  32  to core
- spi_addr_len  out  6  to core
- spi_data_len  out  16  to core
- spi_csreg  out  4  to core
- spi_rd  out  1  one-cycle start pulse, read
- spi_wr  out  1  one-cycle start pulse, write
- spi_swrst  out  1  one-cycle soft-reset pulse to core
- spi_data_tx  out  32  TX data to core
- spi_data_tx_valid  out  1  TX valid to core
- spi_data_tx_ready  in  1  TX ready from core
- spi_data_rx  in  32  RX data from core
- spi_data_rx_valid  in  1  RX valid from core
- spi_data_rx_ready  out  1  RX ready to core

Behaviour:
- Reset (HRESET=1 at a posedge HCLK):
  - State is IDLE; all registered outputs are 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset mid-transfer abandons the transfer: no req_done, no spi_swrst.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, RUN, ABORT, DONE.
- IDLE:
  - If any req_valid is set, grant g, where g = the requester other than last_grant if it is valid, else the valid one.
  - req_ready[g]=1 for exactly this cycle, combinational from IDLE and req_valid.
  - Latch g's descriptor; go to LOAD.
- LOAD:
  - spi_cmd/addr/lens/csreg take the latched descriptor. They stay registered and held until the next LOAD.
  - last_grant<=g. Go to START.
- START: spi_wr (if req_wr[g]) or spi_rd (otherwise) high for this one cycle. Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for spi_status[IDLE_BIT]=0, then go to RUN.
  - If the bit is still 1 after 4 cycles, the transfer is treated as zero-length: go to DONE.
- RUN:
  - TX path, combinational:
    - spi_data_tx = g's TX slice.
    - spi_data_tx_valid = req_tx_valid[g].
    - req_tx_ready[g] = spi_data_tx_ready.
  - RX path, combinational:
    - req_rx_data = spi_data_rx.
    - req_rx_valid[g] = spi_data_rx_valid.
    - spi_data_rx_ready = req_rx_ready[g].
  - Non-granted requester bits are 0.
  - Watchdog counts from 0, saturating. It resets on any TX or RX handshake.
  - spi_status[IDLE_BIT]=1 -> go to DONE.
  - Watchdog == TIMEOUT-1 -> go to ABORT.
  - If both conditions hold in the same cycle, DONE wins.
- ABORT: spi_swrst high for one cycle; err flag set; go to DONE.
- DONE:
  - req_done[g]=1 for one cycle; req_err[g]=err flag.
  - Clear the err flag; go to IDLE.
  - A new grant can occur in the following IDLE cycle.
- Descriptor fields are sampled only at the req_ready cycle. Later changes to requester inputs have no effect on the current transfer.
- Requester data paths are dead outside RUN: all req_tx_ready, req_rx_valid, spi_data_tx_valid and spi_data_rx_ready are 0.

Optional Feature:
- SPI_ARB_LOCK_EN defined:
  - Adds input req_lock (2 bits).
  - In DONE, if req_lock[g]=1, requester g is granted again ahead of round-robin when it is valid in the next IDLE cycle.
  - If g is not valid in that cycle, the lock is dropped.
- Undefined: no req_lock port; pure round-robin.

Test Plan:
- Single read, requester 0: cmd=0x0B, cmd_len=8, addr=0x1000, addr_len=24, data_len=32; core goes busy 2 cycles after the start pulse and returns 1 RX word 0xDEADBEEF.
  -> spi_rd pulses once, 2 cycles after req_ready; req_rx_valid[0] carries 0xDEADBEEF; req_done[0]=1, req_err=0.
- Both req_valid asserted from reset, 3 back-to-back writes each.
  -> grant order 0,1,0,1,0,1; spi_wr count=6; no TX data ever reaches requester 1 while 0 is granted.
- TX backpressure: spi_data_tx_ready held low 100 cycles with TIMEOUT=16.
  -> spi_swrst pulses once ~16 cycles into RUN; req_done[g]=1 with req_err[g]=1.
- Core never goes busy after the start pulse.
  -> DONE 4 cycles after WAIT_BUSY entry; err=0.
- HRESET asserted during RUN.
  -> all outputs 0 on the next edge; no req_done; requester 0 wins the next grant.
- With SPI_ARB_LOCK_EN: req_lock[1]=1, both requesters valid.
  -> requester 1 granted for 3 consecutive transfers; drop the lock -> requester 0 granted next.
